kernel_pos_scanner: RTL and testbench
=====================================

// Module: kernel_pos_scanner
// PURPOSE
//   Raster-scans an IMG_W x IMG_H image and emits, per pixel, the 4-bit kernel
//   position code consumed by the kernel weight mux select input. Driver side of
//   that select interface: tells the mux whether the current pixel is a corner,
//   an edge or an interior pixel. One code per valid/ready transfer, with row/col.
// PARAMETERS
//   IMG_W  8  image width in pixels; legal range >= 2
//   IMG_H  8  image height in pixels; legal range >= 2
//   CW     8  row/col counter width; 2**CW >= max(IMG_W, IMG_H)
// PORTS
//   clk        in   1   clock, all logic on the rising edge
//   rst        in   1   synchronous reset, active-high
//   start      in   1   begin one full-frame scan; sampled only in IDLE
//   out_ready  in   1   downstream accepts the current code
//   out_valid  out  1   select/row/col/last are valid
//   select     out  [0:3] position code; bit 0 is the MSB, same ordering as the mux
//   row        out  CW  row index of the current pixel
//   col        out  CW  column index of the current pixel
//   last       out  1   current pixel is (IMG_H-1, IMG_W-1)
//   busy       out  1   high in SCAN and DONE
//   done       out  1   one-cycle pulse after the last pixel has been accepted
// BEHAVIOUR
//   Reset: state=IDLE; out_valid=0, select=4'b0000, row=0, col=0, last=0,
//     busy=0, done=0. rst wins over every other input on the same edge.
//   FSM: IDLE -> SCAN on start=1 (row=col=0 loaded on that edge).
//     SCAN -> DONE on the transfer of the last pixel. DONE -> IDLE next cycle.
//   Timing: start high at edge N gives out_valid=1 for (0,0) after edge N
//     (1-cycle latency).
//   Transfer = out_valid & out_ready. A transfer with col<IMG_W-1 increments col.
//     A transfer with col==IMG_W-1 sets col=0 and row=row+1.
//     Codes are back-to-back with no bubbles while out_ready stays high.
//   Stall: while out_valid=1 & out_ready=0, select/row/col/last hold stable.
//   Code map (decoded from row/col; registered together with row/col):
//     (0,0)=0001 tl   (0,W-1)=0010 tr   (H-1,0)=0011 bl   (H-1,W-1)=0100 br
//     col=W-1 other rows=0101 r   col=0 other rows=0110 l
//     row=0 other cols=0111 t   row=H-1 other cols=1000 b   interior=1111 c
//     Corner codes take priority over edge codes.
//     Codes 1001-1110 are never emitted.
//   out_valid=0 in IDLE and DONE. select=0000, last=0 whenever out_valid=0.
//   done=1 only in the DONE cycle. busy=1 in SCAN and DONE.
//   start outside IDLE is ignored and does not restart the scan.
//     start held high re-arms in IDLE, so the next frame starts the cycle after DONE.
//   rst during SCAN aborts the frame: next cycle is IDLE with reset outputs, no done.
//   Row/col never exceed IMG_H-1 / IMG_W-1. There is no wrap past the last pixel.
// TESTING
//   IMG_W=4, IMG_H=3, out_ready=1, start pulse -> 12 consecutive codes
//     1,7,7,2, 6,15,15,5, 3,8,8,4.
//     last=1 only on the 12th. done pulses one cycle later, then IDLE.
//   Same frame, out_ready toggled pseudo-randomly -> identical code/row/col
//     sequence; outputs stable on every stalled cycle.
//   start re-asserted at pixel 5 of a scan -> ignored; the sequence continues
//     unchanged and exactly one done pulse occurs.
//   rst asserted with row=1, col=2 -> next cycle out_valid=0, select=0000,
//     busy=0, no done. A new start then begins at (0,0) with code 0001.
//   IMG_W=2, IMG_H=2 -> codes 1,2,3,4 only; no edge or interior codes appear.
//   start held high continuously -> frames repeat with exactly one idle cycle
//     (IDLE) between DONE and the next (0,0).

Source files
------------

// File: rtl/kernel_pos_scanner.sv
// rtl/kernel_pos_scanner.sv - raster scanner emitting kernel position codes
// One registered code per valid/ready transfer; row/col/select/last move together.
module kernel_pos_scanner #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_out_ready,
  output logic          o_out_valid,
  output logic [0:3]    o_select,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_row, r_col, w_row_nx, w_col_nx;
  logic [3:0]    r_select, w_select_nx;
  logic          r_last, w_last_nx;
  logic          w_xfer;

  // Corner tests come first so they win over the plain edge tests.
  function automatic logic [3:0] pos_code(input logic [CW-1:0] r, input logic [CW-1:0] c);
    logic top, bot, lft, rgt;
    top = (r == '0);
    bot = (r == LAST_ROW);
    lft = (c == '0);
    rgt = (c == LAST_COL);
    if (top && lft)      return 4'b0001;
    else if (top && rgt) return 4'b0010;
    else if (bot && lft) return 4'b0011;
    else if (bot && rgt) return 4'b0100;
    else if (rgt)        return 4'b0101;
    else if (lft)        return 4'b0110;
    else if (top)        return 4'b0111;
    else if (bot)        return 4'b1000;
    else                 return 4'b1111;
  endfunction

  assign w_xfer = (r_state == S_SCAN) && i_out_ready;

  always_comb begin
    w_next      = r_state;
    w_row_nx    = r_row;
    w_col_nx    = r_col;
    w_select_nx = 4'b0000;
    w_last_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next   = S_SCAN;
          w_row_nx = '0;
          w_col_nx = '0;
        end
      end
      S_SCAN: begin
        if (w_xfer) begin
          if (r_last) begin
            w_next   = S_DONE;
            w_row_nx = '0;
            w_col_nx = '0;
          end else if (r_col == LAST_COL) begin
            w_col_nx = '0;
            w_row_nx = r_row + CW'(1);
          end else begin
            w_col_nx = r_col + CW'(1);
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // A stalled cycle recomputes the same code from unchanged row/col.
    if (w_next == S_SCAN) begin
      w_select_nx = pos_code(w_row_nx, w_col_nx);
      w_last_nx   = (w_row_nx == LAST_ROW) && (w_col_nx == LAST_COL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_select <= 4'b0000;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_row    <= w_row_nx;
      r_col    <= w_col_nx;
      r_select <= w_select_nx;
      r_last   <= w_last_nx;
    end
  end

  assign o_out_valid = (r_state == S_SCAN);
  assign o_select    = r_select;
  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_last      = r_last;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_kernel_pos_scanner.sv
// tb/tb_kernel_pos_scanner.sv - self-checking bench for kernel_pos_scanner
module tb_kernel_pos_scanner;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_start = 1'b0, a_ready = 1'b1;
  logic          a_valid, a_last, a_busy, a_done;
  logic [0:3]    a_select;
  logic [CW-1:0] a_row, a_col;
  logic          b_start = 1'b0, b_ready = 1'b1;
  logic          b_valid, b_last, b_busy, b_done;
  logic [0:3]    b_select;
  logic [CW-1:0] b_row, b_col;

  int vectors = 0;
  int miscompares = 0;
  int golden[12] = '{1, 7, 7, 2, 6, 15, 15, 5, 3, 8, 8, 4};

  always #5 clk = ~clk;

  kernel_pos_scanner #(.IMG_W(4), .IMG_H(3), .CW(CW)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_out_ready(a_ready),
    .o_out_valid(a_valid), .o_select(a_select), .o_row(a_row), .o_col(a_col),
    .o_last(a_last), .o_busy(a_busy), .o_done(a_done)
  );

  kernel_pos_scanner #(.IMG_W(2), .IMG_H(2), .CW(CW)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_out_ready(b_ready),
    .o_out_valid(b_valid), .o_select(b_select), .o_row(b_row), .o_col(b_col),
    .o_last(b_last), .o_busy(b_busy), .o_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference classification of a pixel by its place in the W x H frame.
  function automatic int exp_code(input int r, input int c, input int w, input int h);
    bit top = (r == 0), bot = (r == h - 1), lft = (c == 0), rgt = (c == w - 1);
    if (top && lft) return 1;
    if (top && rgt) return 2;
    if (bot && lft) return 3;
    if (bot && rgt) return 4;
    if (rgt) return 5;
    if (lft) return 6;
    if (top) return 7;
    if (bot) return 8;
    return 15;
  endfunction

  task automatic check_idle_a(input string tag);
    check({tag, "_valid"}, a_valid, 0);
    check({tag, "_select"}, a_select, 0);
    check({tag, "_last"}, a_last, 0);
    check({tag, "_busy"}, a_busy, 0);
    check({tag, "_done"}, a_done, 0);
  endtask

  // 4x3 frame: optional random stalls, optional start pulse mid-scan, optional held start.
  task automatic run_frame_a(input bit rnd_ready, input bit restart_mid, input bit hold, input bit use_golden);
    int idx = 0;
    int cyc = 0;
    a_start = 1'b1;
    tick();
    a_start = hold;
    while (idx < 12 && cyc < 400) begin
      check("a_valid", a_valid, 1);
      check("a_select", a_select, exp_code(idx / 4, idx % 4, 4, 3));
      if (use_golden) check("a_golden", a_select, golden[idx]);
      check("a_row", a_row, idx / 4);
      check("a_col", a_col, idx % 4);
      check("a_last", a_last, (idx == 11));
      check("a_busy", a_busy, 1);
      check("a_done_early", a_done, 0);
      a_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      a_start = hold | (restart_mid && idx == 5);
      if (a_ready) idx++;
      tick();
      cyc++;
    end
    check("a_frame_timeout", (cyc < 400), 1);
    a_start = hold;
    a_ready = 1'b1;
    check("a_done_pulse", a_done, 1);
    check("a_done_busy", a_busy, 1);
    check("a_done_valid", a_valid, 0);
    check("a_done_select", a_select, 0);
    check("a_done_last", a_last, 0);
    tick();
    check_idle_a("a_post");
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b1;
    tick();
    tick();
    check_idle_a("a_reset");
    check("a_reset_row", a_row, 0);
    check("a_reset_col", a_col, 0);
    check("b_reset_valid", b_valid, 0);
    check("b_reset_busy", b_busy, 0);
    rst = 1'b0;
    a_start = 1'b0;
    tick();
    check_idle_a("a_idle");

    run_frame_a(1'b0, 1'b0, 1'b0, 1'b1);
    run_frame_a(1'b1, 1'b0, 1'b0, 1'b1);
    run_frame_a(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_idle_a("a_after_restart");

    // Abort with row=1, col=2 (pixel index 6).
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("a_pre_abort_row", a_row, 1);
    check("a_pre_abort_col", a_col, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_a("a_abort");
    check("a_abort_row", a_row, 0);
    check("a_abort_col", a_col, 0);
    tick();
    check_idle_a("a_abort_nodone");
    run_frame_a(1'b0, 1'b0, 1'b0, 1'b1);

    run_frame_a(1'b0, 1'b0, 1'b1, 1'b0);
    run_frame_a(1'b0, 1'b0, 1'b1, 1'b0);
    a_start = 1'b0;

    // 2x2 frame: corner codes only.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_valid", b_valid, 1);
      check("b_select", b_select, exp_code(i / 2, i % 2, 2, 2));
      check("b_corner_only", (b_select >= 1 && b_select <= 4), 1);
      check("b_row", b_row, i / 2);
      check("b_col", b_col, i % 2);
      check("b_last", b_last, (i == 3));
      tick();
    end
    check("b_done", b_done, 1);
    check("b_done_valid", b_valid, 0);
    tick();
    check("b_idle_busy", b_busy, 0);
    check("b_idle_done", b_done, 0);

    // Reset beats start on the same edge.
    rst = 1'b1;
    a_start = 1'b1;
    tick();
    rst = 1'b0;
    a_start = 1'b0;
    check_idle_a("a_rst_vs_start");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
